// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: opcode/state enums and command record for counter_cmd_sequencer
package counter_seq_pkg;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_HOLD = 2'b11} op_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_e;
  localparam int CMD_DATA_W = 4;
  localparam int CMD_LEN_W = 8;
  typedef struct packed {
    op_e                  op;
    logic [CMD_DATA_W-1:0] data;
    logic [CMD_LEN_W-1:0]  len;
  } cmd_t;
endpackage

// File: rtl/cnt_cmd_fifo.sv
// cnt_cmd_fifo: power-of-two command queue with flush; push while full is allowed when a pop happens on the same edge
module cnt_cmd_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_dout  = r_mem[r_rp];
  // pointers and occupancy; flush empties the queue in one edge
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage array written at the tail
  always_ff @(posedge i_clk)
    if (w_push && !i_flush) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: queued LOAD/UP/DOWN/HOLD command executor driving a counter; CNT_SEQ_FIFO_EN selects a FIFO_DEPTH queue, else a single holding register
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int HOW_MANY_BITS = 4,
  parameter int LEN_BITS      = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [1:0]               CMD_OP,
  input  logic [HOW_MANY_BITS-1:0] CMD_DATA,
  input  logic [LEN_BITS-1:0]      CMD_LEN,
  input  logic                     ABORT,
  output logic [HOW_MANY_BITS-1:0] IN,
  output logic                     LOAD,
  output logic                     UP_or_DOWN,
  output logic                     START_or_STOP,
  output logic                     BUSY,
  output logic                     DONE
);
  typedef struct packed {
    op_e                      op;
    logic [HOW_MANY_BITS-1:0] data;
    logic [LEN_BITS-1:0]      len;
  } cmd_w_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two of at least 2");
  end

  cmd_w_t                   w_in_cmd, w_head;
  logic                     w_push, w_pop, w_full, w_empty, w_last;
  state_e                   r_state, w_state_nxt;
  op_e                      r_op, w_op_nxt;
  logic [LEN_BITS-1:0]      r_rem, w_rem_nxt;
  logic [HOW_MANY_BITS-1:0] r_in, w_in_nxt;
  logic                     r_dir, w_dir_nxt;

  assign w_in_cmd  = '{op: op_e'(CMD_OP), data: CMD_DATA, len: CMD_LEN};
  assign CMD_READY = RST_N && !w_full && !ABORT;
  assign w_push    = CMD_VALID && CMD_READY;
  assign w_last    = (r_state == ST_EXEC) && (r_op == OP_LOAD || r_rem <= LEN_BITS'(1));
  assign w_pop     = !w_empty && !ABORT && (r_state == ST_IDLE || w_last);

`ifdef CNT_SEQ_FIFO_EN
  cnt_cmd_fifo #(.W($bits(cmd_w_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_flush(ABORT),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_in_cmd),
    .o_dout (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
`else
  logic   r_hold_v;
  cmd_w_t r_hold;
  assign w_head  = r_hold;
  assign w_full  = r_hold_v;
  assign w_empty = !r_hold_v;
  // single-entry holding register; only refilled once the FSM has taken its contents
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_hold_v <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_hold_v <= !ABORT && (w_push || (r_hold_v && !w_pop));
      if (w_push) r_hold <= w_in_cmd;
    end
`endif

  // FSM and execution registers
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_rem   <= '0;
      r_in    <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_rem   <= w_rem_nxt;
      r_in    <= w_in_nxt;
      r_dir   <= w_dir_nxt;
    end

  // next state: abort wins, then pop (from IDLE or the final EXEC cycle), then completion, else count down
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_rem_nxt   = r_rem;
    w_in_nxt    = r_in;
    w_dir_nxt   = r_dir;
    if (ABORT) w_state_nxt = ST_IDLE;
    else if (w_pop) begin
      w_state_nxt = ST_EXEC;
      w_op_nxt    = w_head.op;
      w_rem_nxt   = w_head.len;
      w_in_nxt    = w_head.op == OP_LOAD ? w_head.data : r_in;
      w_dir_nxt   = (w_head.op == OP_UP || w_head.op == OP_DOWN) ? w_head.op == OP_DOWN : r_dir;
    end else if (w_last) w_state_nxt = ST_IDLE;
    else if (r_state == ST_EXEC) w_rem_nxt = r_rem - LEN_BITS'(1);
  end

  assign IN            = r_in;
  assign UP_or_DOWN    = r_dir;
  assign LOAD          = (r_state == ST_EXEC) && (r_op == OP_LOAD);
  assign START_or_STOP = (r_state == ST_EXEC) && (r_op == OP_LOAD || (r_op != OP_HOLD && r_rem != '0));
  assign BUSY          = (r_state == ST_EXEC) || !w_empty;
  assign DONE          = w_last && !ABORT;
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: directed commands with a completion scoreboard checked on each DONE pulse
module tb_counter_cmd_sequencer;
  import counter_seq_pkg::*;
  logic       CLK = 0, RST_N = 0, CMD_VALID = 0, ABORT = 0;
  logic [1:0] CMD_OP = 0;
  logic [3:0] CMD_DATA = 0;
  logic [7:0] CMD_LEN = 0;
  logic       CMD_READY, LOAD, UP_or_DOWN, START_or_STOP, BUSY, DONE;
  logic [3:0] IN;
  int total = 0, bad = 0;
  typedef struct {int load; int start; int dir; int in; int len;} exp_t;
  exp_t sb[$];
  int   run_cnt = 0;
  logic prev_busy = 0;
  logic [3:0] tcnt = 0;

  counter_cmd_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_LEN(CMD_LEN), .ABORT(ABORT),
    .IN(IN), .LOAD(LOAD), .UP_or_DOWN(UP_or_DOWN), .START_or_STOP(START_or_STOP),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input op_e op, input int data, input int len);
    exp_t e;
    e.load  = int'(op == OP_LOAD);
    e.start = op == OP_LOAD ? 1 : op == OP_HOLD ? 0 : int'(len != 0);
    e.dir   = (op == OP_UP && len != 0) ? 0 : (op == OP_DOWN && len != 0) ? 1 : -1;
    e.in    = op == OP_LOAD ? data : -1;
    e.len   = (op == OP_LOAD || len == 0) ? 1 : len;
    return e;
  endfunction

  // a 4-bit counter wired to the sequencer outputs
  always @(posedge CLK)
    if (LOAD) tcnt <= IN;
    else if (START_or_STOP) tcnt <= UP_or_DOWN ? tcnt - 4'd1 : tcnt + 4'd1;

  // monitor: measure each command's EXEC length and check its outputs when DONE pulses
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_busy = 0;
      run_cnt = 0;
    end else begin
      if (DONE) begin
        chk("done_has_entry", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("run_len", run_cnt + 1, e.len);
          chk("load_at_done", LOAD, e.load);
          chk("start_at_done", START_or_STOP, e.start);
          if (e.dir >= 0) chk("dir_at_done", UP_or_DOWN, e.dir);
          if (e.in >= 0) chk("in_at_done", IN, e.in);
        end
        run_cnt = 0;
      end else if (BUSY && prev_busy) run_cnt++;
      else run_cnt = 0;
      prev_busy = BUSY;
    end
  end

  task automatic send(input op_e op, input int data, input int len);
    int n = 0;
    CMD_OP = op;
    CMD_DATA = 4'(data);
    CMD_LEN = 8'(len);
    CMD_VALID = 1;
    while (!CMD_READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready_timeout", CMD_READY, 1);
    if (CMD_READY) sb.push_back(mk(op, data, len));
    @(negedge CLK);
    CMD_VALID = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_timeout_busy", BUSY, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_in", IN, 0);
    chk("rst_load", LOAD, 0);
    chk("rst_dir", UP_or_DOWN, 0);
    chk("rst_start", START_or_STOP, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_ready", CMD_READY, 0);
    RST_N = 1;
    @(negedge CLK);
    chk("idle_ready", CMD_READY, 1);
    // LOAD 9: drives two cycles after accept, for one cycle
    send(OP_LOAD, 9, 0);
    chk("load_latency_not_yet", LOAD, 0);
    chk("busy_when_queued", BUSY, 1);
    @(negedge CLK);
    chk("load9_load", LOAD, 1);
    chk("load9_in", IN, 9);
    chk("load9_start", START_or_STOP, 1);
    chk("load9_done", DONE, 1);
    @(negedge CLK);
    chk("load9_load_off", LOAD, 0);
    chk("load9_start_off", START_or_STOP, 0);
    chk("load9_in_held", IN, 9);
    chk("load9_busy_off", BUSY, 0);
    // UP 5 then DOWN 3 back-to-back on a counter loaded with 0
    send(OP_LOAD, 0, 0);
    wait_idle();
    send(OP_UP, 0, 5);
    send(OP_DOWN, 0, 3);
    wait_idle();
    chk("counter_end", tcnt, 2);
    // queue fills behind a long HOLD
    send(OP_HOLD, 0, 20);
    @(negedge CLK);
    chk("hold_busy", BUSY, 1);
    chk("hold_start", START_or_STOP, 0);
    send(OP_UP, 0, 3);
`ifndef CNT_SEQ_FIFO_EN
    chk("holdreg_ready_low", CMD_READY, 0);
`endif
    send(OP_DOWN, 0, 2);
    send(OP_HOLD, 0, 2);
    send(OP_DOWN, 0, 3);
`ifdef CNT_SEQ_FIFO_EN
    chk("full_ready_low", CMD_READY, 0);
    begin
      int n = 0;
      while (!DONE && n < 100) begin
        @(negedge CLK);
        n++;
      end
    end
    chk("hold_done_seen", DONE, 1);
    chk("ready_low_at_pop", CMD_READY, 0);
    @(negedge CLK);
    chk("ready_after_pop", CMD_READY, 1);
`endif
    send(OP_LOAD, 7, 0);
    wait_idle();
    chk("in_after_load7", IN, 7);
    // ABORT during a long DOWN with commands queued and one offered
    send(OP_DOWN, 0, 200);
    send(OP_UP, 0, 3);
`ifdef CNT_SEQ_FIFO_EN
    send(OP_UP, 0, 4);
`endif
    repeat (2) @(negedge CLK);
    CMD_OP = OP_LOAD;
    CMD_DATA = 4'd5;
    CMD_VALID = 1;
    ABORT = 1;
    chk("abort_ready", CMD_READY, 0);
    @(posedge CLK);
    sb.delete();
    @(negedge CLK);
    CMD_VALID = 0;
    ABORT = 0;
    chk("abort_busy", BUSY, 0);
    chk("abort_start", START_or_STOP, 0);
    chk("abort_done", DONE, 0);
    repeat (3) @(negedge CLK);
    chk("abort_dropped_cmd", BUSY, 0);
    chk("abort_in_kept", IN, 7);
    // asynchronous reset in the middle of a HOLD
    send(OP_HOLD, 0, 50);
    repeat (5) @(negedge CLK);
    #2 RST_N = 0;
    CMD_VALID = 1;
    #1;
    chk("arst_in", IN, 0);
    chk("arst_load", LOAD, 0);
    chk("arst_dir", UP_or_DOWN, 0);
    chk("arst_start", START_or_STOP, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    chk("arst_ready", CMD_READY, 0);
    sb.delete();
    repeat (3) @(negedge CLK);
    CMD_VALID = 0;
    RST_N = 1;
    @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);
    // zero-length UP: one stopped EXEC cycle with DONE
    send(OP_UP, 0, 0);
    @(negedge CLK);
    chk("len0_start", START_or_STOP, 0);
    chk("len0_done", DONE, 1);
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
